c17_rr_arbiter: RTL and testbench
=================================

C17_RR_ARBITER -- requirements
Module: c17_rr_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, SHALL select round-robin arbitration (1) or fixed priority with requester A winning (0).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 a_valid  input  1  SHALL indicate that requester A presents an operand.
REQ-005 a_data  input  5  SHALL carry A's operand, bit order {in7,in6,in3,in2,in1}, so that bit0=in1 and bit4=in7.
REQ-006 a_ready  output  1  SHALL indicate that A's operand is accepted this cycle.
REQ-007 b_valid, b_data[4:0], b_ready SHALL be identical in meaning to the A ports, for requester B.
REQ-008 out_valid  output  1  SHALL indicate that a result is held.
REQ-009 out_data  output  2  SHALL carry the result as {o23,o22}.
REQ-010 out_tag  output  1  SHALL identify the originating requester: 0 for A, 1 for B.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-012 busy  output  1  SHALL be high whenever either pipeline stage holds an entry.

Function
REQ-013 The block SHALL implement the shared evaluator as follows (c17 logic): n9=in3&in6; n10=in2&~n9; o22=(in1&in3)|n10; o23=n10|(in7&~n9).
REQ-014 The pipeline SHALL have two stages:
- S1 holds the operand and tag.
- S2 holds the registered result and tag.
- out_valid, out_data and out_tag SHALL be driven directly from S2.
REQ-015 S2 SHALL load when S1 is valid and either S2 is empty or out_ready=1.
REQ-016 S1 SHALL accept a new operand when S1 is empty or S1 advances in the same cycle.
REQ-017 Transfer on a requester port SHALL occur exactly when valid&ready=1 at a clock edge.
REQ-018 At most one of a_ready/b_ready SHALL be high per cycle.
REQ-019 a_ready/b_ready SHALL be low when S1 cannot accept.
REQ-020 a_ready/b_ready SHALL depend combinationally only on a_valid, b_valid, the pointer and the pipeline state, never on a_data or b_data.
REQ-021 Arbitration when exactly one requester is valid: that requester SHALL be granted.
REQ-022 Arbitration when both are valid and ROUND_ROBIN=1: the requester named by the 1-bit pointer SHALL be granted.
REQ-023 After every completed transfer, the pointer SHALL be set to the non-granted requester.
REQ-024 With ROUND_ROBIN=0 the pointer SHALL be held at A.
REQ-025 A requester that is valid but not granted SHALL have its operand neither consumed nor altered.
REQ-026 Latency: an operand accepted at edge N SHALL produce out_valid=1 after edge N+1, provided out_ready was not low in a way that blocked S2.
REQ-027 Throughput with out_ready held at 1 SHALL be one result per cycle.
REQ-028 While out_valid=1 and out_ready=0, out_data and out_tag SHALL remain stable.
REQ-029 While out_valid=1 and out_ready=0, S1 SHALL still accept an operand if S1 is empty.
REQ-030 When both stages are full and out_ready=0, both ready outputs SHALL be 0.
REQ-031 When both stages are full and out_ready=1, S2 SHALL drain, S1 SHALL advance, and a new operand SHALL be accepted, all in the same cycle, with no bubble.
REQ-032 Results SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-033 The pointer SHALL change only on a completed transfer, never on a blocked request.

Reset
REQ-034 While rst=1, regardless of clk, the following SHALL hold:
- S1 and S2 empty;
- out_valid=0, out_data=2'b00, out_tag=0;
- a_ready=0, b_ready=0, busy=0;
- pointer=A.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight entries; no result SHALL emerge after deassertion.
REQ-036 The first cycle after deassertion SHALL allow acceptance.

Verification
REQ-037 Single path: A sends 5'b00101 with out_ready=1 -> out_data=2'b01, out_tag=0, two edges after acceptance.
REQ-038 Function values: B sends 5'b11110 -> out_data=2'b00, tag 1; A sends 5'b10010 -> out_data=2'b11, tag 0.
REQ-039 Contention: both valid continuously with ROUND_ROBIN=1, out_ready=1 -> grants A,B,A,B, with tags 0,1,0,1 one per cycle. With ROUND_ROBIN=0 -> all grants go to A.
REQ-040 Backpressure: out_ready=0 for 5 cycles with both requesters valid -> exactly 2 entries accepted, then readies low and out_data stable. Releasing out_ready -> results drain in order with no loss.
REQ-041 Reset mid-flight: rst pulsed while both stages are full -> out_valid=0 immediately (asynchronous) and no stale result afterwards.
REQ-042 Randomized valid/ready stimulus against a reference queue model -> every result matches the equations in REQ-013 and its tag.

Source files
------------

// File: rtl/c17_rr_arbiter.sv
// Two-requester arbiter feeding a two-stage pipelined c17 evaluator.
// Round-robin or fixed-priority (A wins) grant, valid/ready on every port.
module c17_rr_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [4:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [4:0] b_data,
  output logic       b_ready,
  output logic       out_valid,
  output logic [1:0] out_data,
  output logic       out_tag,
  input  logic       out_ready,
  output logic       busy
);

  // Operand bit order is {in7,in6,in3,in2,in1}; result is {o23,o22}.
  function automatic logic [1:0] c17(input logic [4:0] d);
    logic in1, in2, in3, in6, in7;
    logic n9, n10, o22, o23;
    in1 = d[0];
    in2 = d[1];
    in3 = d[2];
    in6 = d[3];
    in7 = d[4];
    n9  = in3 & in6;
    n10 = in2 & ~n9;
    o22 = (in1 & in3) | n10;
    o23 = n10 | (in7 & ~n9);
    return {o23, o22};
  endfunction

  logic       s1_valid;
  logic [4:0] s1_data;
  logic       s1_tag;
  logic       s2_valid;
  logic [1:0] s2_data;
  logic       s2_tag;
  logic       ptr;

  logic       s2_load;
  logic       can_accept;
  logic       sel_b;
  logic       a_fire;
  logic       b_fire;
  logic       xfer;
  logic [4:0] in_data;

  assign s2_load    = s1_valid & (~s2_valid | out_ready);
  assign can_accept = ~rst & (~s1_valid | s2_load);

  // ptr=1 names B; in fixed-priority mode it never leaves A.
  assign sel_b   = b_valid & (~a_valid | ptr);
  assign a_ready = can_accept & a_valid & ~sel_b;
  assign b_ready = can_accept & sel_b;

  assign a_fire  = a_valid & a_ready;
  assign b_fire  = b_valid & b_ready;
  assign xfer    = a_fire | b_fire;
  assign in_data = b_fire ? b_data : a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (xfer) begin
      ptr <= a_fire && (ROUND_ROBIN != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= 1'b0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_tag   <= b_fire;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= c17(s1_data);
      s2_tag   <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_c17_rr_arbiter.sv
// Directed and randomized checks of c17_rr_arbiter in both
// round-robin and fixed-priority configurations.
module tb_c17_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, out_ready;
  logic [4:0] a_data, b_data;

  logic       a_ready, b_ready, out_valid, out_tag, busy;
  logic [1:0] out_data;
  logic       f_a_ready, f_b_ready, f_out_valid, f_out_tag, f_busy;
  logic [1:0] f_out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  c17_rr_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
    .out_ready(out_ready), .busy(busy)
  );

  c17_rr_arbiter #(.ROUND_ROBIN(0)) fdut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(f_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(f_b_ready),
    .out_valid(f_out_valid), .out_data(f_out_data), .out_tag(f_out_tag),
    .out_ready(out_ready), .busy(f_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the evaluator; result is {tag, o23, o22}.
  function automatic logic [2:0] ref_c17(input logic tag,
                                          input logic [4:0] d);
    logic i1, i2, i3, i6, i7;
    logic y22, y23;
    {i7, i6, i3, i2, i1} = d;
    y22 = (i1 & i3) | (i2 & ~(i3 & i6));
    y23 = (i2 & ~(i3 & i6)) | (i7 & ~(i3 & i6));
    return {tag, y23, y22};
  endfunction

  logic [2:0] q[$];
  logic [2:0] exp_e;

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = '0; b_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_busy", busy, 0);
    step(); step();

    // Single path on A
    rst = 1'b0; b_valid = 1'b0;
    a_valid = 1'b1; a_data = 5'b00101;
    #1;
    chk("first_cycle_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    #1;
    chk("lat_not_yet", out_valid, 0);
    chk("lat_busy", busy, 1);
    step(); #1;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 2'b01);
    chk("single_tag", out_tag, 0);
    step(); #1;
    chk("single_drained", out_valid, 0);
    chk("single_idle", busy, 0);

    // B then A back-to-back
    b_valid = 1'b1; b_data = 5'b11110;
    #1;
    chk("b_only_ready", b_ready, 1);
    step();
    b_valid = 1'b0; a_valid = 1'b1; a_data = 5'b10010;
    #1;
    chk("a_follow_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    #1;
    chk("b_val_data", out_data, 2'b00);
    chk("b_val_tag", out_tag, 1);
    step(); #1;
    chk("a_val_valid", out_valid, 1);
    chk("a_val_data", out_data, 2'b11);
    chk("a_val_tag", out_tag, 0);
    step(); #1;
    chk("pair_drained", out_valid, 0);

    // Backpressure with both valid; pointer currently names B
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 5'b10010;
    b_valid = 1'b1; b_data = 5'b11110;
    #1;
    chk("bp0_b_ready", b_ready, 1);
    chk("bp0_a_ready", a_ready, 0);
    step(); #1;
    chk("bp1_a_ready", a_ready, 1);
    chk("bp1_b_ready", b_ready, 0);
    step(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_full_a_ready", a_ready, 0);
      chk("bp_full_b_ready", b_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 2'b00);
      chk("bp_hold_tag", out_tag, 1);
      step(); #1;
    end
    chk("bp_end_a_ready", a_ready, 0);
    chk("bp_end_data", out_data, 2'b00);
    out_ready = 1'b1; a_valid = 1'b0;
    #1;
    chk("full_drain_accept", b_ready, 1);
    step();
    b_valid = 1'b0;
    #1;
    chk("drain1_data", out_data, 2'b11);
    chk("drain1_tag", out_tag, 0);
    step(); #1;
    chk("drain2_valid", out_valid, 1);
    chk("drain2_data", out_data, 2'b00);
    chk("drain2_tag", out_tag, 1);
    step(); #1;
    chk("drain_empty", busy, 0);

    // Fill both stages, then reset mid-flight
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 5'b00101;
    step();
    a_valid = 1'b0;
    step(); #1;
    chk("fill_s2_valid", out_valid, 1);
    b_valid = 1'b1; b_data = 5'b10010;
    #1;
    chk("s1_empty_accepts", b_ready, 1);
    step(); #1;
    chk("full_b_ready", b_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_busy", busy, 0);
    chk("async_b_ready", b_ready, 0);
    step();
    rst = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    step(); #1;
    chk("no_stale1", out_valid, 0);
    step(); #1;
    chk("no_stale2", out_valid, 0);
    chk("no_stale_busy", busy, 0);

    // Contention; pointer is back at A after reset
    a_valid = 1'b1; a_data = 5'b00101;
    b_valid = 1'b1; b_data = 5'b10010;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_a_ready", a_ready, (i % 2) == 0);
      chk("rr_b_ready", b_ready, (i % 2) == 1);
      chk("fp_a_ready", f_a_ready, 1);
      chk("fp_b_ready", f_b_ready, 0);
      if (i >= 2) begin
        chk("rr_out_tag", out_tag, (i % 2) == 1);
        chk("rr_out_data", out_data, (i % 2) ? 2'b11 : 2'b01);
        chk("fp_out_tag", f_out_tag, 0);
        chk("fp_out_data", f_out_data, 2'b01);
      end
      step(); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();

    // Randomized traffic against a reference queue
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_data = 5'($urandom);
      b_data = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_one_hot", a_ready & b_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_spurious", out_valid, 0);
        end else begin
          exp_e = q.pop_front();
          chk("rand_result", {out_tag, out_data}, exp_e);
        end
      end
      if (a_valid && a_ready) q.push_back(ref_c17(1'b0, a_data));
      if (b_valid && b_ready) q.push_back(ref_c17(1'b1, b_data));
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("drain_spurious", out_valid, 0);
        end else begin
          exp_e = q.pop_front();
          chk("drain_result", {out_tag, out_data}, exp_e);
        end
      end
      step();
    end
    chk("rand_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
